// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: packs host bytes little-endian into words and
// writes them from address 0 while holding the core in reset. Optional readback: VERIFY_EN.
module imem_loader #(
  parameter int MEM_SIZE  = 128,
  parameter int WORD_SIZE = 32,
  localparam int AW  = $clog2(MEM_SIZE),
  localparam int NW  = $clog2(MEM_SIZE + 1),
  localparam int BPW = WORD_SIZE / 8,
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NW-1:0]        num_words,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  input  logic [AW-1:0]        cpu_addr,
  output logic                 mem_wr,
  output logic [AW-1:0]        mem_in_addr,
  output logic [WORD_SIZE-1:0] mem_in_data,
  output logic [AW-1:0]        mem_out_addr,
  input  logic [WORD_SIZE-1:0] mem_out_data,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 len_err,
  output logic                 verify_err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t               state;
  logic [AW-1:0]        word_idx;
  logic [BW-1:0]        byte_idx;
  logic [WORD_SIZE-1:0] asm_reg;
  logic [NW-1:0]        cnt;
  logic                 verify_flag;
  logic                 last_word;

  // cnt is never 0 outside IDLE/DONE, so cnt-1 cannot underflow where it is used
  assign last_word = (NW'(word_idx) == cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      word_idx    <= '0;
      byte_idx    <= '0;
      asm_reg     <= '0;
      cnt         <= '0;
      len_err     <= 1'b0;
      verify_flag <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt         <= (num_words > NW'(MEM_SIZE)) ? NW'(MEM_SIZE) : num_words;
            len_err     <= (num_words > NW'(MEM_SIZE));
            verify_flag <= 1'b0;
            word_idx    <= '0;
            byte_idx    <= '0;
            state       <= (num_words == '0) ? DONE : RECV;
          end
        end
        RECV: begin
          if (byte_valid) begin
            asm_reg[8*byte_idx +: 8] <= byte_data;
            if (byte_idx == BW'(BPW - 1)) begin
              byte_idx <= '0;
              state    <= WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
`ifdef VERIFY_EN
          state <= VERIFY;
`else
          if (last_word) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= RECV;
          end
`endif
        end
`ifdef VERIFY_EN
        VERIFY: begin
          if (mem_out_data != asm_reg)
            verify_flag <= 1'b1;
          if (last_word) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= RECV;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_ready  = (state == RECV);
  assign mem_wr      = (state == WRITE);
  assign mem_in_addr = word_idx;
  assign mem_in_data = asm_reg;
  assign done        = (state == DONE);
  assign cpu_hold    = (state != DONE);

`ifdef VERIFY_EN
  assign busy         = (state == RECV) || (state == WRITE) || (state == VERIFY);
  assign mem_out_addr = (state == VERIFY) ? word_idx : cpu_addr;
  assign verify_err   = verify_flag;
`else
  assign busy         = (state == RECV) || (state == WRITE);
  assign mem_out_addr = cpu_addr;
  assign verify_err   = 1'b0;
  wire   unused_verify = ^{verify_flag, mem_out_data};
`endif

endmodule
